// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CR16-subset multicycle controller:
// FSM states, opcode fields, condition codes, ALU functions and datapath mux selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_BRANCH = 3'd4,
    S_JUMP   = 3'd5
  } state_t;

  localparam logic [3:0] P_RTYPE = 4'b0000;
  localparam logic [3:0] P_ANDI  = 4'b0001;
  localparam logic [3:0] P_ORI   = 4'b0010;
  localparam logic [3:0] P_XORI  = 4'b0011;
  localparam logic [3:0] P_MEMJ  = 4'b0100;
  localparam logic [3:0] P_ADDI  = 4'b0101;
  localparam logic [3:0] P_SHIFT = 4'b1000;
  localparam logic [3:0] P_SUBI  = 4'b1001;
  localparam logic [3:0] P_CMPI  = 4'b1011;
  localparam logic [3:0] P_BCOND = 4'b1100;
  localparam logic [3:0] P_MOVI  = 4'b1101;
  localparam logic [3:0] P_LUI   = 4'b1111;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LSHI  = 4'b0000;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_MOV, ALU_LSH, ALU_LUI
  } alu_op_t;

  localparam logic [1:0] PC_SEL_INC  = 2'd0;
  localparam logic [1:0] PC_SEL_DISP = 2'd1;
  localparam logic [1:0] PC_SEL_REG  = 2'd2;
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  typedef enum logic [2:0] {
    CL_ILLEGAL, CL_ALU, CL_LOAD, CL_STOR, CL_BCOND, CL_JCOND, CL_JAL
  } iclass_t;

  typedef struct packed {
    iclass_t cls;
    alu_op_t alu;
    logic    imm;
    logic    wr;
    logic    psr;
  } dec_t;

  // Undefined opcodes come back as CL_ILLEGAL with no write, no flags and ALU_NOP.
  function automatic dec_t decode_op(input logic [7:0] op);
    dec_t       d;
    logic [3:0] p;
    logic [3:0] e;
    p     = op[7:4];
    e     = op[3:0];
    d.cls = CL_ILLEGAL;
    d.alu = ALU_NOP;
    d.imm = 1'b0;
    d.wr  = 1'b0;
    d.psr = 1'b0;
    case (p)
      P_RTYPE: begin
        d.cls = CL_ALU;
        d.wr  = 1'b1;
        case (e)
          EXT_ADD: begin d.alu = ALU_ADD; d.psr = 1'b1; end
          EXT_SUB: begin d.alu = ALU_SUB; d.psr = 1'b1; end
          EXT_CMP: begin d.alu = ALU_CMP; d.psr = 1'b1; d.wr = 1'b0; end
          EXT_AND: d.alu = ALU_AND;
          EXT_OR:  d.alu = ALU_OR;
          EXT_XOR: d.alu = ALU_XOR;
          EXT_MOV: d.alu = ALU_MOV;
          default: begin d.cls = CL_ILLEGAL; d.wr = 1'b0; end
        endcase
      end
      P_ADDI: begin d.cls = CL_ALU; d.alu = ALU_ADD; d.imm = 1'b1; d.wr = 1'b1; d.psr = 1'b1; end
      P_SUBI: begin d.cls = CL_ALU; d.alu = ALU_SUB; d.imm = 1'b1; d.wr = 1'b1; d.psr = 1'b1; end
      P_CMPI: begin d.cls = CL_ALU; d.alu = ALU_CMP; d.imm = 1'b1; d.psr = 1'b1; end
      P_ANDI: begin d.cls = CL_ALU; d.alu = ALU_AND; d.imm = 1'b1; d.wr = 1'b1; end
      P_ORI:  begin d.cls = CL_ALU; d.alu = ALU_OR;  d.imm = 1'b1; d.wr = 1'b1; end
      P_XORI: begin d.cls = CL_ALU; d.alu = ALU_XOR; d.imm = 1'b1; d.wr = 1'b1; end
      P_MOVI: begin d.cls = CL_ALU; d.alu = ALU_MOV; d.imm = 1'b1; d.wr = 1'b1; end
      P_LUI:  begin d.cls = CL_ALU; d.alu = ALU_LUI; d.imm = 1'b1; d.wr = 1'b1; end
      P_SHIFT: begin
        if (e == EXT_LSH || e == EXT_LSHI) begin
          d.cls = CL_ALU;
          d.alu = ALU_LSH;
          d.imm = (e == EXT_LSHI);
          d.wr  = 1'b1;
        end
      end
      P_MEMJ: begin
        case (e)
          EXT_LOAD:  d.cls = CL_LOAD;
          EXT_STOR:  d.cls = CL_STOR;
          EXT_JAL:   d.cls = CL_JAL;
          EXT_JCOND: d.cls = CL_JCOND;
          default:   d.cls = CL_ILLEGAL;
        endcase
      end
      P_BCOND: d.cls = CL_BCOND;
      default: d.cls = CL_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_fsm_cond_eval.sv
// Branch/jump condition evaluator: cond code against PSR flags {C,L,F,Z,N}.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_true
);

  logic w_c, w_l, w_f, w_z, w_n;
  assign {w_c, w_l, w_f, w_z, w_n} = flags;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = w_z;
      COND_NE: cond_true = !w_z;
      COND_CS: cond_true = w_c;
      COND_CC: cond_true = !w_c;
      COND_HI: cond_true = w_l;
      COND_LS: cond_true = !w_l;
      COND_GT: cond_true = w_n;
      COND_LE: cond_true = !w_n;
      COND_FS: cond_true = w_f;
      COND_FC: cond_true = !w_f;
      COND_LO: cond_true = !w_l && !w_z;
      COND_HS: cond_true = w_l || w_z;
      COND_LT: cond_true = !w_n && !w_z;
      COND_GE: cond_true = w_n || w_z;
      COND_UC: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle FETCH/DECODE/EXEC sequencer for the CR16-subset core; outputs are
// decoded combinationally from state, the held opcode, flags and mem_ready.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int ALU_OPW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         opcode,
  input  logic [3:0]         cond,
  input  logic [4:0]         flags,
  input  logic               mem_ready,
  output logic               ir_en,
  output logic               pc_en,
  output logic [1:0]         pc_sel,
  output logic               reg_we,
  output logic [1:0]         wb_sel,
  output logic               imm_sel,
  output logic [ALU_OPW-1:0] alu_op,
  output logic               psr_en,
  output logic               mem_en,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               illegal
);

  state_t r_state;
  dec_t   w_dec;
  logic   w_cond_true;

  assign w_dec = decode_op(opcode);

  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags),
    .cond_true (w_cond_true)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_dec.cls)
            CL_LOAD, CL_STOR:  r_state <= S_MEM;
            CL_BCOND:          r_state <= S_BRANCH;
            CL_JCOND, CL_JAL:  r_state <= S_JUMP;
            default:           r_state <= S_EXEC;
          endcase
        end
        S_MEM:    if (mem_ready) r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Reset forces every output low so an aborted access never reaches the bus.
  always_comb begin
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = PC_SEL_INC;
    reg_we   = 1'b0;
    wb_sel   = WB_SEL_ALU;
    imm_sel  = 1'b0;
    alu_op   = '0;
    psr_en   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_en = 1'b1;
          ir_en  = mem_ready;
        end
        S_DECODE: begin
          imm_sel = w_dec.imm;
          illegal = (w_dec.cls == CL_ILLEGAL);
        end
        S_EXEC: begin
          pc_en   = 1'b1;
          imm_sel = w_dec.imm;
          alu_op  = ALU_OPW'(w_dec.alu);
          reg_we  = w_dec.wr;
          psr_en  = w_dec.psr;
        end
        S_MEM: begin
          mem_en   = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (w_dec.cls == CL_STOR);
          if (mem_ready) begin
            pc_en = 1'b1;
            if (w_dec.cls == CL_LOAD) begin
              reg_we = 1'b1;
              wb_sel = WB_SEL_MEM;
            end
          end
        end
        S_BRANCH: begin
          pc_en  = 1'b1;
          pc_sel = w_cond_true ? PC_SEL_DISP : PC_SEL_INC;
        end
        S_JUMP: begin
          pc_en = 1'b1;
          if (w_dec.cls == CL_JAL) begin
            reg_we = 1'b1;
            wb_sel = WB_SEL_LINK;
            pc_sel = PC_SEL_REG;
          end else begin
            pc_sel = w_cond_true ? PC_SEL_REG : PC_SEL_INC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction timelines from an opcode-table model.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic [3:0] cond;
  logic [4:0] flags;
  logic       mem_ready;
  logic       ir_en, pc_en, reg_we, imm_sel, psr_en, mem_en, mem_we, addr_sel, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_fsm #(.ALU_OPW(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cond(cond), .flags(flags),
    .mem_ready(mem_ready), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_op(alu_op),
    .psr_en(psr_en), .mem_en(mem_en), .mem_we(mem_we), .addr_sel(addr_sel),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       psr_en;
    logic       mem_en;
    logic       mem_we;
    logic       addr_sel;
    logic       illegal;
  } outs_t;

  outs_t act;
  assign act = {ir_en, pc_en, pc_sel, reg_we, wb_sel, psr_en, mem_en, mem_we, addr_sel, illegal};

  localparam int K_ALU = 0, K_LOAD = 1, K_STOR = 2, K_BR = 3, K_JC = 4, K_JAL = 5, K_ILL = 6;

  typedef struct {
    int   kind;
    logic wr;
    logic psr;
    logic imm;
  } ref_t;

  function automatic ref_t ref_class(input logic [7:0] op);
    ref_t r;
    r.kind = K_ILL; r.wr = 1'b0; r.psr = 1'b0; r.imm = 1'b0;
    case (op)
      8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0B, 8'h0D: begin
        r.kind = K_ALU;
        r.wr   = (op != 8'h0B);
        r.psr  = (op == 8'h05 || op == 8'h09 || op == 8'h0B);
      end
      8'h80, 8'h84: begin r.kind = K_ALU; r.wr = 1'b1; end
      8'h40: r.kind = K_LOAD;
      8'h44: r.kind = K_STOR;
      8'h48: r.kind = K_JAL;
      8'h4C: r.kind = K_JC;
      default: begin
        if (op[7:4] == 4'hC) r.kind = K_BR;
        else if (op[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF}) begin
          r.kind = K_ALU;
          r.imm  = 1'b1;
          r.wr   = (op[7:4] != 4'hB);
          r.psr  = (op[7:4] inside {4'h5, 4'h9, 4'hB});
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = f;
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fl;
      4'd5:  return !fl;
      4'd6:  return fn;
      4'd7:  return !fn;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !fl && !fz;
      4'd11: return fl || fz;
      4'd12: return !fn && !fz;
      4'd13: return fn || fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One full instruction: fw fetch wait cycles, decode, then the final phase (mw waits for memory).
  task automatic run_instr(input string nm, input logic [7:0] op, input logic [3:0] c,
                           input logic [4:0] f, input int fw, input int mw);
    ref_t  r;
    logic  ct;
    outs_t e;
    int    npc;
    int    nfin;
    r = ref_class(op);
    ct = ref_cond(c, f);
    npc = 0;
    opcode = op; cond = c; flags = f;
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      e = '0; e.mem_en = 1'b1; e.ir_en = mem_ready;
      @(negedge clk);
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s fetch%0d op=%h: got %h expected %h", nm, i, op, act, e);
      end
      if (pc_en) npc++;
      @(posedge clk); #1;
    end
    mem_ready = 1'($urandom_range(0, 1));
    e = '0; e.illegal = (r.kind == K_ILL);
    @(negedge clk);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s decode op=%h: got %h expected %h", nm, op, act, e);
    end
    if (pc_en) npc++;
    @(posedge clk); #1;
    nfin = (r.kind == K_LOAD || r.kind == K_STOR) ? mw + 1 : 1;
    for (int i = 0; i < nfin; i++) begin
      if (r.kind == K_LOAD || r.kind == K_STOR) mem_ready = (i == mw);
      else mem_ready = 1'($urandom_range(0, 1));
      e = '0;
      case (r.kind)
        K_LOAD: begin
          e.mem_en = 1'b1; e.addr_sel = 1'b1;
          if (mem_ready) begin e.reg_we = 1'b1; e.wb_sel = 2'd1; e.pc_en = 1'b1; end
        end
        K_STOR: begin
          e.mem_en = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
          if (mem_ready) e.pc_en = 1'b1;
        end
        K_BR:  begin e.pc_en = 1'b1; e.pc_sel = ct ? 2'd1 : 2'd0; end
        K_JC:  begin e.pc_en = 1'b1; e.pc_sel = ct ? 2'd2 : 2'd0; end
        K_JAL: begin e.pc_en = 1'b1; e.reg_we = 1'b1; e.wb_sel = 2'd2; e.pc_sel = 2'd2; end
        default: begin e.pc_en = 1'b1; e.reg_we = r.wr; e.psr_en = r.psr; end
      endcase
      @(negedge clk);
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s final%0d op=%h cond=%h flags=%b: got %h expected %h",
                 nm, i, op, c, f, act, e);
      end
      if (r.kind == K_ALU && op[7:4] != 4'h8) begin
        n_tests++;
        if (imm_sel !== r.imm) begin
          n_fail++;
          $display("FAIL %s imm_sel op=%h: got %b expected %b", nm, op, imm_sel, r.imm);
        end
      end
      if (pc_en) npc++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (npc != 1) begin
      n_fail++;
      $display("FAIL %s pc_en_count op=%h: got %0d expected 1", nm, op, npc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 8'($urandom); cond = 4'($urandom); flags = 5'($urandom);
      @(negedge clk);
      n_tests++;
      if (act !== '0 || alu_op !== 4'd0 || imm_sel !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got %h/%h/%b expected 0", i, act, alu_op, imm_sel);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    run_instr("add", 8'h05, 4'h0, 5'b0, 0, 0);
    run_instr("movi", 8'hD7, 4'h3, 5'b10101, 1, 0);
    run_instr("cmp", 8'h0B, 4'h0, 5'b0, 0, 0);
    run_instr("lsh", 8'h84, 4'h2, 5'b0, 2, 0);
  endtask

  task automatic test_load_wait();
    run_instr("load_wait", 8'h40, 4'h1, 5'b0, 0, 2);
    run_instr("load_fast", 8'h40, 4'h1, 5'b0, 0, 0);
    run_instr("stor_wait", 8'h44, 4'h1, 5'b0, 1, 1);
  endtask

  task automatic test_branch();
    run_instr("beq_z1", 8'hC0, 4'b0000, 5'b00010, 0, 0);
    run_instr("beq_z0", 8'hC0, 4'b0000, 5'b11101, 0, 0);
    run_instr("buc", 8'hC3, 4'b1110, 5'b00000, 0, 0);
    run_instr("bnv", 8'hC3, 4'b1111, 5'b11111, 0, 0);
  endtask

  task automatic test_jump();
    run_instr("jal", 8'h48, 4'h0, 5'b0, 0, 0);
    run_instr("jcond_t", 8'h4C, 4'b1011, 5'b00010, 0, 0);
    run_instr("jcond_f", 8'h4C, 4'b1010, 5'b00010, 0, 0);
    run_instr("cmpi", 8'hB2, 4'h0, 5'b0, 0, 0);
  endtask

  task automatic test_illegal();
    int n_ill;
    n_ill = 0;
    opcode = 8'h4F;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (illegal) n_ill++;
        end
      end
      run_instr("illegal", 8'h4F, 4'h0, 5'b0, 0, 0);
    join
    n_tests++;
    if (n_ill != 1) begin
      n_fail++;
      $display("FAIL illegal_pulse_width: got %0d cycles expected 1", n_ill);
    end
  endtask

  task automatic test_reset_mid_access();
    outs_t e;
    opcode = 8'h44; cond = 4'h0; flags = 5'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    e = '0; e.mem_en = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
    @(negedge clk);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL stor_mem_wait: got %h expected %h", act, e);
    end
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_in_mem: got %h expected 0", act);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    e = '0; e.mem_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL fetch_after_mem_reset: got %h expected %h", act, e);
    end
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_with_ready_in_fetch: got %h expected 0", act);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL fetch_after_fetch_reset: got %h expected %h", act, e);
    end
    @(posedge clk); #1;
    run_instr("add_after_reset", 8'h05, 4'h0, 5'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] pool [28] = '{8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h53,
                              8'h9A, 8'hB3, 8'h1F, 8'h27, 8'h3C, 8'hD1, 8'hF0, 8'h80,
                              8'h84, 8'h40, 8'h44, 8'hC5, 8'h4C, 8'h48, 8'h4F, 8'h00,
                              8'h8F, 8'h6A, 8'hE2, 8'h7B};
    logic [7:0] op;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = pool[$urandom_range(0, 27)];
      run_instr("random", op, 4'($urandom), 5'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 8'h00; cond = 4'h0; flags = 5'b0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
